sa_result_collector: RTL

//  Receiving end of the systolic array's result-drain chain. Each column's bottom PE shifts out accumulated

---
 rtl/sa_pkg.sv | 35 +++
 rtl/sa_col_fifo.sv | 56 +++++
 rtl/sa_result_collector.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_pkg
// Brief    : Shared widths, default configuration and result-entry layout for
//            the systolic-array result collector.
// Revision : 1.0 - initial release
// ============================================================================
package sa_pkg;

  // Default configuration of the PE grid feeding the collector.
  localparam int SA_D_W        = 8;
  localparam int SA_ACC_W      = 2 * SA_D_W;
  localparam int SA_N          = 4;
  localparam int SA_M          = 4;
  localparam int SA_FIFO_DEPTH = 8;

  // Index width for a counter over n values; never narrower than one bit so
  // degenerate 1-row / 1-column grids still get a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SA_ROW_W = idx_w(SA_N);
  localparam int SA_COL_W = idx_w(SA_M);

  // Layout of one buffered result for the default grid: row tag above the
  // accumulated value. The collector packs entries with the same ordering
  // for any parameter override.
  typedef struct packed {
    logic [SA_ROW_W-1:0] row;
    logic [SA_ACC_W-1:0] data;
  } sa_entry_t;

endpackage
`default_nettype wire

// File: rtl/sa_col_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sa_col_fifo
// Brief    : Synchronous single-clock FIFO for one array column. Read data is
//            the head entry, valid whenever empty is low; no write-to-read
//            bypass. A push into a full FIFO is accepted only when a pop
//            happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sa_col_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO without clearing storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; ignored during reset so a discarded tile leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/sa_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : sa_result_collector
// Brief    : Captures unthrottled per-column result beats from the bottom row
//            of the PE grid into per-column FIFOs with row tags, then drains
//            one tile column by column onto a ready/valid stream tagged with
//            row/column indices and an end-of-tile marker.
// Revision : 1.0 - initial release
// ============================================================================
module sa_result_collector
  import sa_pkg::*;
#(
  parameter int  D_W        = SA_D_W,
  parameter int  N          = SA_N,
  parameter int  M          = SA_M,
  parameter int  FIFO_DEPTH = SA_FIFO_DEPTH,
  localparam int ACC_W      = 2 * D_W,
  localparam int ROW_W      = idx_w(N),
  localparam int COL_W      = idx_w(M)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [M*ACC_W-1:0] col_data,
  input  logic [M-1:0]       col_valid,
  output logic [ACC_W-1:0]   m_data,
  output logic [ROW_W-1:0]   m_row,
  output logic [COL_W-1:0]   m_col,
  output logic               m_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               overflow,
  output logic               busy
);

  localparam int ENT_W = ROW_W + ACC_W;

  logic [ROW_W-1:0] row_cnt [M];
  logic [ENT_W-1:0] fifo_q  [M];
  logic [M-1:0]     fifo_full;
  logic [M-1:0]     fifo_empty;
  logic [M-1:0]     pop_vec;
  logic [M-1:0]     drop_vec;

  logic [COL_W-1:0] cur_col;
  logic [COL_W-1:0] cur_col_nxt;
  logic [ROW_W-1:0] cur_row_cnt;
  logic [ROW_W-1:0] cur_row_nxt;
  logic [ENT_W-1:0] head;
  logic             load;

  // One FIFO per column; the bottom PE shifts the last row out first, so the
  // k-th beat of a tile belongs to row N-1-k.
  for (genvar c = 0; c < M; c++) begin : g_col
    logic [ENT_W-1:0] push_ent;

    assign push_ent    = {ROW_W'(N-1) - row_cnt[c], col_data[c*ACC_W +: ACC_W]};
    assign drop_vec[c] = col_valid[c] && fifo_full[c] && !pop_vec[c];

    sa_col_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (col_valid[c]),
      .push_data (push_ent),
      .pop       (pop_vec[c]),
      .pop_data  (fifo_q[c]),
      .full      (fifo_full[c]),
      .empty     (fifo_empty[c])
    );
  end

  // Arrival counters advance on every beat, dropped or not, so the tags of
  // later beats stay aligned with the physical row order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < M; c++) row_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < M; c++) begin
        if (col_valid[c]) begin
          row_cnt[c] <= (row_cnt[c] == ROW_W'(N-1)) ? '0 : row_cnt[c] + ROW_W'(1);
        end
      end
    end
  end

  assign head = fifo_q[cur_col];
  assign load = (!m_valid || m_ready) && !fifo_empty[cur_col];
  assign busy = !(&fifo_empty) || m_valid;

  // Only the column currently being drained is ever popped.
  always_comb begin
    pop_vec = '0;
    for (int c = 0; c < M; c++) begin
      pop_vec[c] = load && (cur_col == COL_W'(c));
    end
  end

  // Drain position register: column being drained and results taken from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_col     <= '0;
      cur_row_cnt <= '0;
    end else begin
      cur_col     <= cur_col_nxt;
      cur_row_cnt <= cur_row_nxt;
    end
  end

  // Drain position advance: N results per column, columns 0..M-1 per tile.
  always_comb begin
    cur_col_nxt = cur_col;
    cur_row_nxt = cur_row_cnt;
    if (load) begin
      if (cur_row_cnt == ROW_W'(N-1)) begin
        cur_row_nxt = '0;
        cur_col_nxt = (cur_col == COL_W'(M-1)) ? '0 : cur_col + COL_W'(1);
      end else begin
        cur_row_nxt = cur_row_cnt + ROW_W'(1);
      end
    end
  end

  // Output register: refills whenever it is free or being accepted, holds
  // steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_row   <= '0;
      m_col   <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= head[ACC_W-1:0];
      m_row   <= head[ENT_W-1:ACC_W];
      m_col   <= cur_col;
      m_last  <= (cur_col == COL_W'(M-1)) && (cur_row_cnt == ROW_W'(N-1));
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Sticky overflow: any beat lost to a full column FIFO.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (|drop_vec) overflow <= 1'b1;
  end

endmodule
`default_nettype wire
